if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch front end. It produces the IF_Instruction / IF_PC_4 stream that the IFID_Reg pipeline register latches.
- Consumes the stall and redirect decisions made in ID: PCWrite from Hazard_detection_unit, Branch/BTB_Addr from Branch_calc and ADD2, and Jump/Jump_Addr from Control and ADD3.
- Fetches from instruction memory over a req/ack handshake with variable latency.
- Holds one fetched instruction in a single-entry buffer, and discards wrong-path responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- NOP_WORD, 32'h0000_0000: value driven on IF_Instruction when no valid instruction is buffered.

Ports:
- CLK, in, 1: clock, rising edge.
- RESET, in, 1: synchronous, active-high reset.
- PCWrite, in, 1: 1 = pipeline advances and IFID latches this cycle; 0 = stall.
- Branch, in, 1: taken branch resolved in ID.
- BTB_Addr, in, 32: branch target.
- Jump, in, 2: 00 = none, 01 = j/jal, 10 = jr, 11 = treated as 01.
- Jump_Addr, in, 32: j/jal target.
- JR_Addr, in, 32: jr target (forwarded RS value).
- IMEM_Req, out, 1: fetch request.
- IMEM_Addr, out, 32: fetch address; bits [1:0] always 00.
- IMEM_Ack, in, 1: response strobe; IMEM_Data is valid in the same cycle.
- IMEM_Data, in, 32: fetched word.
- IF_Instruction, out, 32: instruction to IFID_Reg.
- IF_PC_4, out, 32: address of that instruction + 4.
- IF_Valid, out, 1: buffer holds a valid instruction.

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-high (RESET).
- Registers: PC (next address to fetch), DROP_ADDR, BUF, BUF_PC4, BUF_V, and state in {S_REQ, S_FULL, S_DROP}.
- Reset (RESET=1 at edge):
  - PC <= RESET_PC; BUF, BUF_PC4 <= 0; BUF_V <= 0; state <= S_REQ.
  - While RESET=1, IMEM_Req=0.
  - Reset mid-request abandons the request. The memory must cancel when Req drops, and any Ack seen during reset is ignored.
- Outputs:
  - IF_Instruction = BUF_V ? BUF : NOP_WORD.
  - IF_PC_4 = BUF_PC4.
  - IF_Valid = BUF_V.
  - A missing instruction reaches IFID as a NOP bubble.
- Redirect:
  - redirect = PCWrite & (Branch | Jump != 00).
  - Target = Branch ? BTB_Addr : (Jump == 10 ? JR_Addr : Jump_Addr), with bits [1:0] forced to 00.
  - Branch has priority over Jump.
  - Branch/Jump are ignored while PCWrite=0.
- Arithmetic: PC+4 is modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
- Memory contract: once IMEM_Req=1, Req and Addr are held stable until the Ack cycle. One request is outstanding at most.
- S_REQ (BUF_V=0): IMEM_Req=1, IMEM_Addr=PC.
  - redirect & Ack: data discarded; PC <= target; stay S_REQ.
  - redirect & !Ack: DROP_ADDR <= PC; PC <= target; go S_DROP.
  - Ack (no redirect): BUF <= IMEM_Data; BUF_PC4 <= PC+4; BUF_V <= 1; PC <= PC+4; go S_FULL. PCWrite is irrelevant here.
  - Otherwise: hold.
- S_FULL (BUF_V=1):
  - PCWrite=0: IMEM_Req=0; all state held.
  - redirect: IMEM_Req=0; BUF_V <= 0; PC <= target; go S_REQ. The buffered word is wrong-path; IFID is flushed by the hazard unit.
  - PCWrite=1, no redirect (buffer consumed): IMEM_Req=1 combinationally, IMEM_Addr=PC.
    - Ack: BUF <= IMEM_Data; BUF_PC4 <= PC+4; PC <= PC+4; stay S_FULL. This gives one instruction per cycle.
    - No Ack: BUF_V <= 0; go S_REQ, with the request continuing.
- S_DROP (BUF_V=0): IMEM_Req=1, IMEM_Addr=DROP_ADDR.
  - redirect: PC <= new target, and the state is unchanged.
  - Ack: data discarded; go S_REQ, where fetching continues from PC.
- Latency: with a zero-wait memory (Ack in the Req cycle), the first valid instruction appears 1 cycle after the first request cycle. A redirect costs 1 bubble.
- IMEM_Addr is 0 while IMEM_Req=0.

Test Plan:
- Zero-wait memory, PCWrite=1 throughout, mem[a]=a|0xA000_0000:
  - After RESET falls, IF_Valid=1 from the 2nd cycle.
  - IF_PC_4 = 4, 8, 12, 16 on consecutive cycles.
  - IF_Instruction = 0xA000_0000, 0xA000_0004, …
  - IMEM_Req stays 1.
- Memory with Ack 2 cycles after Req rises, PCWrite=1:
  - IF_Valid pattern 0,0,1 repeats.
  - IF_Instruction = NOP_WORD (0) when invalid.
  - IMEM_Addr stable 0x0 until the first Ack, then 0x4.
- Stall with BUF_V=1, IF_PC_4=0x8, PCWrite=0 for 3 cycles:
  - IF_Instruction and IF_PC_4 unchanged.
  - IMEM_Req=0.
  - On PCWrite=1, the next request address is 0x8.
- Redirect during a pending fetch (3-cycle memory, S_REQ at PC=0xC), Branch=1, BTB_Addr=0x40 with PCWrite=1:
  - Req stays at 0xC until its Ack, which is discarded (IF_Valid stays 0).
  - Next request is 0x40; then IF_PC_4=0x44.
- Target priority:
  - Branch=1, Jump=01, BTB_Addr=0x80, Jump_Addr=0x200: next request address 0x80.
  - Branch=0, Jump=10, JR_Addr=0x103: next request address 0x100.
  - Branch=1 with PCWrite=0: no redirect.
- Boundaries:
  - With RESET_PC=0xFFFF_FFFC, the first IF_PC_4=0x0 and the next request address is 0x0.
  - RESET asserted while Req pending: IMEM_Req=0 and IF_Valid=0 at the next edge; fetching restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC sequencing, req/ack instruction-memory fetch,
// single-entry instruction buffer and wrong-path response discard after redirects.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PCWrite,
    input  logic        Branch,
    input  logic [31:0] BTB_Addr,
    input  logic [1:0]  Jump,
    input  logic [31:0] Jump_Addr,
    input  logic [31:0] JR_Addr,
    output logic        IMEM_Req,
    output logic [31:0] IMEM_Addr,
    input  logic        IMEM_Ack,
    input  logic [31:0] IMEM_Data,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC_4,
    output logic        IF_Valid
);

    typedef enum logic [1:0] {S_REQ, S_FULL, S_DROP} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_buf;
    logic [31:0] r_buf_pc4;
    logic        r_buf_v;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_drop_nxt;
    logic [31:0] w_buf_nxt;
    logic [31:0] w_buf_pc4_nxt;
    logic        w_buf_v_nxt;
    logic        w_req;
    logic        w_addr_drop;
    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    assign w_redirect = PCWrite & (Branch | (Jump != 2'b00));
    // Branch wins over any jump; jump code 11 falls through to the j/jal target.
    assign w_target   = (Branch ? BTB_Addr : ((Jump == 2'b10) ? JR_Addr : Jump_Addr))
                        & 32'hFFFF_FFFC;
    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_drop_nxt    = r_drop_addr;
        w_buf_nxt     = r_buf;
        w_buf_pc4_nxt = r_buf_pc4;
        w_buf_v_nxt   = r_buf_v;
        w_req         = 1'b0;
        w_addr_drop   = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req = 1'b1;
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                    if (!IMEM_Ack) begin
                        w_drop_nxt  = r_pc;
                        w_state_nxt = S_DROP;
                    end
                end else if (IMEM_Ack) begin
                    w_buf_nxt     = IMEM_Data;
                    w_buf_pc4_nxt = w_pc_plus4;
                    w_buf_v_nxt   = 1'b1;
                    w_pc_nxt      = w_pc_plus4;
                    w_state_nxt   = S_FULL;
                end
            end
            S_FULL: begin
                if (w_redirect) begin
                    w_buf_v_nxt = 1'b0;
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end else if (PCWrite) begin
                    // Buffer is being consumed; refill it in the same cycle if memory allows.
                    w_req = 1'b1;
                    if (IMEM_Ack) begin
                        w_buf_nxt     = IMEM_Data;
                        w_buf_pc4_nxt = w_pc_plus4;
                        w_pc_nxt      = w_pc_plus4;
                    end else begin
                        w_buf_v_nxt = 1'b0;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_DROP: begin
                w_req       = 1'b1;
                w_addr_drop = 1'b1;
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                end
                if (IMEM_Ack) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_drop_addr <= 32'h0;
            r_buf       <= 32'h0;
            r_buf_pc4   <= 32'h0;
            r_buf_v     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop_addr <= w_drop_nxt;
            r_buf       <= w_buf_nxt;
            r_buf_pc4   <= w_buf_pc4_nxt;
            r_buf_v     <= w_buf_v_nxt;
        end
    end

    assign IMEM_Req       = w_req & ~RESET;
    assign IMEM_Addr      = IMEM_Req ? ((w_addr_drop ? r_drop_addr : r_pc) & 32'hFFFF_FFFC)
                                     : 32'h0;
    assign IF_Instruction = r_buf_v ? r_buf : NOP_WORD;
    assign IF_PC_4        = r_buf_pc4;
    assign IF_Valid       = r_buf_v;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus randomized traffic against a
// request-tracking reference model and a variable-latency memory.
module tb_if_fetch_unit;

    logic        CLK = 1'b0;
    logic        rst, pcw, br;
    logic [1:0]  jmp;
    logic [31:0] btb, ja, jra;
    logic        req, ack;
    logic [31:0] addr, data;
    logic [31:0] instr, pc4;
    logic        valid;

    logic        req2, ack2, valid2;
    logic [31:0] addr2, data2, instr2, pc42;

    int vectors = 0;
    int miscompares = 0;

    // Memory model state
    int  lat_fixed = 0;
    bit  lat_rand = 1'b0;
    int  cur_lat = 0;
    int  cnt = 0;

    // Reference model: next fetch PC, buffer, and the one outstanding request
    logic [31:0] m_pc, m_buf, m_bpc4, m_oaddr;
    logic        m_bv, m_outp, m_owrong;

    logic        last_req;
    logic [31:0] last_addr;
    int          guard;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'hA000_0000;
    endfunction

    if_fetch_unit dut (
        .CLK(CLK), .RESET(rst), .PCWrite(pcw), .Branch(br), .BTB_Addr(btb),
        .Jump(jmp), .Jump_Addr(ja), .JR_Addr(jra),
        .IMEM_Req(req), .IMEM_Addr(addr), .IMEM_Ack(ack), .IMEM_Data(data),
        .IF_Instruction(instr), .IF_PC_4(pc4), .IF_Valid(valid)
    );

    assign ack2  = req2;
    assign data2 = memword(addr2);

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_WORD(32'h0)) dut2 (
        .CLK(CLK), .RESET(rst), .PCWrite(1'b1), .Branch(1'b0), .BTB_Addr(32'h0),
        .Jump(2'b00), .Jump_Addr(32'h0), .JR_Addr(32'h0),
        .IMEM_Req(req2), .IMEM_Addr(addr2), .IMEM_Ack(ack2), .IMEM_Data(data2),
        .IF_Instruction(instr2), .IF_PC_4(pc42), .IF_Valid(valid2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        e_req, redir, cur_wrong, s_req, s_ack;
        logic [31:0] e_addr, tgt;
        @(negedge CLK);
        if (rst) begin
            ack  = 1'($urandom_range(0, 1));
            data = $urandom;
        end else if (req) begin
            if (cnt == 0) cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
            ack  = (cnt >= cur_lat);
            data = ack ? memword(addr) : $urandom;
        end else begin
            ack  = 1'b0;
            data = $urandom;
        end
        redir  = pcw & (br | (jmp != 2'b00));
        tgt    = (br ? btb : ((jmp == 2'b10) ? jra : ja)) & 32'hFFFF_FFFC;
        e_addr = 32'h0;
        if (rst)                e_req = 1'b0;
        else if (m_outp)        begin e_req = 1'b1; e_addr = m_oaddr; end
        else if (!m_bv)         begin e_req = 1'b1; e_addr = m_pc; end
        else if (pcw && !redir) begin e_req = 1'b1; e_addr = m_pc; end
        else                    e_req = 1'b0;
        check("imem_req", {31'b0, req}, {31'b0, e_req});
        check("imem_addr", addr, e_req ? e_addr : 32'h0);
        last_req = req; last_addr = addr;
        s_req = req; s_ack = ack;
        if (rst) begin
            m_pc = 32'h0; m_bv = 1'b0; m_buf = 32'h0; m_bpc4 = 32'h0;
            m_outp = 1'b0; m_owrong = 1'b0; m_oaddr = 32'h0;
        end else begin
            cur_wrong = m_outp & m_owrong;
            if (redir) begin
                if (m_bv) m_bv = 1'b0;
                else if (e_req) begin
                    if (ack) begin m_outp = 1'b0; m_owrong = 1'b0; end
                    else begin m_outp = 1'b1; m_owrong = 1'b1; m_oaddr = e_addr; end
                end
                m_pc = tgt;
            end else if (e_req) begin
                if (ack) begin
                    if (!cur_wrong) begin
                        m_bv = 1'b1; m_buf = memword(e_addr);
                        m_bpc4 = e_addr + 32'd4; m_pc = e_addr + 32'd4;
                    end
                    m_outp = 1'b0; m_owrong = 1'b0;
                end else begin
                    m_outp = 1'b1; m_owrong = cur_wrong; m_oaddr = e_addr; m_bv = 1'b0;
                end
            end
        end
        @(posedge CLK);
        #1;
        if (rst || !s_req || s_ack) cnt = 0;
        else cnt++;
        check("if_valid", {31'b0, valid}, {31'b0, m_bv});
        check("if_instr", instr, m_bv ? m_buf : 32'h0);
        check("if_pc4", pc4, m_bpc4);
    endtask

    task automatic do_reset(input int lat);
        lat_fixed = lat; lat_rand = 1'b0;
        rst = 1'b1; pcw = 1'b1; br = 1'b0; jmp = 2'b00;
        step(); step();
        check("reset_valid", {31'b0, valid}, 32'h0);
        check("reset_pc4", pc4, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pcw = 1'b1; br = 1'b0; jmp = 2'b00;
        btb = 32'h0; ja = 32'h0; jra = 32'h0; ack = 1'b0; data = 32'h0;
        m_pc = 32'h0; m_bv = 1'b0; m_buf = 32'h0; m_bpc4 = 32'h0;
        m_outp = 1'b0; m_owrong = 1'b0; m_oaddr = 32'h0;
        last_req = 1'b0; last_addr = 32'h0;

        // Zero-wait streaming
        do_reset(0);
        step();
        check("zw_first_valid", {31'b0, valid}, 32'h1);
        check("zw_first_pc4", pc4, 32'h4);
        check("zw_first_instr", instr, 32'hA000_0000);
        check("wrap_pc4", pc42, 32'h0);
        check("wrap_instr", instr2, 32'h5FFF_FFFC);
        check("wrap_next_addr", addr2, 32'h0);
        for (int k = 2; k <= 4; k++) begin
            step();
            check("zw_req", {31'b0, last_req}, 32'h1);
            check("zw_pc4", pc4, 32'(4 * k));
            check("zw_instr", instr, 32'hA000_0000 | 32'(4 * k - 4));
        end

        // Two-wait memory: valid pattern 0,0,1
        do_reset(2);
        for (int k = 0; k < 6; k++) begin
            step();
            check("w2_valid", {31'b0, valid}, (k % 3 == 2) ? 32'h1 : 32'h0);
            check("w2_addr", last_addr, (k < 3) ? 32'h0 : 32'h4);
            if (k % 3 != 2) check("w2_nop", instr, 32'h0);
        end

        // Stall with buffer full
        pcw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_req", {31'b0, last_req}, 32'h0);
            check("stall_addr", last_addr, 32'h0);
            check("stall_pc4", pc4, 32'h8);
            check("stall_instr", instr, 32'hA000_0004);
        end
        pcw = 1'b1;
        step();
        check("stall_resume_addr", last_addr, 32'h8);

        // Redirect during a pending fetch
        do_reset(3);
        guard = 0;
        while (!(valid && pc4 == 32'hC) && guard < 60) begin step(); guard++; end
        check("reach_pc4_c", (guard < 60) ? 32'h1 : 32'h0, 32'h1);
        step();
        br = 1'b1; btb = 32'h40;
        step();
        check("redir_hold_addr", last_addr, 32'hC);
        br = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("drop_addr", last_addr, 32'hC);
            check("drop_valid", {31'b0, valid}, 32'h0);
        end
        step();
        check("redir_new_addr", last_addr, 32'h40);
        guard = 0;
        while (!valid && guard < 8) begin step(); guard++; end
        check("redir_pc4", pc4, 32'h44);

        // Target priority
        do_reset(0);
        step(); step(); step();
        br = 1'b1; jmp = 2'b01; btb = 32'h80; ja = 32'h200;
        step();
        br = 1'b0; jmp = 2'b00;
        step();
        check("prio_branch_addr", last_addr, 32'h80);
        check("prio_branch_pc4", pc4, 32'h84);
        jmp = 2'b10; jra = 32'h103;
        step();
        jmp = 2'b00;
        step();
        check("prio_jr_addr", last_addr, 32'h100);
        br = 1'b1; btb = 32'h300; pcw = 1'b0;
        step();
        br = 1'b0; pcw = 1'b1;
        step();
        check("prio_stalled_branch", last_addr, 32'h104);

        // Reset while a request is pending
        do_reset(3);
        step(); step();
        rst = 1'b1;
        step();
        check("rst_mid_req", {31'b0, last_req}, 32'h0);
        check("rst_mid_valid", {31'b0, valid}, 32'h0);
        rst = 1'b0;
        step();
        check("rst_restart_addr", last_addr, 32'h0);
        check("rst_restart_req", {31'b0, last_req}, 32'h1);

        // Randomized traffic
        lat_rand = 1'b1;
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            pcw = ($urandom_range(0, 9) < 8);
            br  = ($urandom_range(0, 9) == 0);
            jmp = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            btb = $urandom; ja = $urandom; jra = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
